// File: rtl/uart_frame_check.sv
// uart_frame_check
//   Takes the sampled bits of a UART receiver, starting with the first data
//   bit after the start bit. It rebuilds the data word (LSB first), checks the
//   optional parity bit (none/even/odd/mark/space) and the stop bits, and
//   reports each frame with a one-cycle frame_done pulse. It also keeps two
//   saturating error counters.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   parity_mode[2:0]  000 none, 001 even, 010 odd, 011 mark, 100 space;
//                     any other code is treated as none
//   sample_valid      strobe: serial_in holds a sampled bit
//   serial_in         sampled line value
//   abort             drop the frame in progress and go back to idle
//   clear_counts      zero both error counters
//   data_out          word from the last completed frame
//   frame_done        one-cycle pulse, one clock after the last stop strobe
//   parity_err        parity result of the last frame, held between frames
//   frame_err         a stop bit of the last frame was 0, held between frames
//   parity_err_count  saturating count of frames with a parity error
//   frame_err_count   saturating count of frames with a frame error
module uart_frame_check #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           parity_mode,
  input  logic                 sample_valid,
  input  logic                 serial_in,
  input  logic                 abort,
  input  logic                 clear_counts,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     parity_err_count,
  output logic [CNT_W-1:0]     frame_err_count
);

  // One counter serves both the data bits and the stop bits.
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [2:0]           mode_reg;
  logic                 acc_reg;
  logic                 perr_reg;
  logic                 ferr_reg;
  logic [DATA_BITS-1:0] shift_reg;

  logic step;
  logic bit_we;
  logic data_last;
  logic stop_last;
  logic expected_parity;

  function automatic logic has_parity(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd4);
  endfunction

  // abort overrides a strobe in the same cycle, so that bit is dropped.
  assign step = sample_valid & ~abort;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else if (sample_valid) begin
      case (state_reg)
        S_IDLE: begin
          // The mode is latched on this strobe, so decode the live input here.
          if (DATA_BITS == 1) state_next = has_parity(parity_mode) ? S_PARITY : S_STOP;
          else                state_next = S_DATA;
        end
        S_DATA: begin
          if (cnt_reg == LAST_DATA) state_next = has_parity(mode_reg) ? S_PARITY : S_STOP;
        end
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          if (cnt_reg == LAST_STOP) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output/control decode
  always_comb begin
    bit_we          = 1'b0;
    data_last       = 1'b0;
    stop_last       = 1'b0;
    expected_parity = 1'b0;
    case (state_reg)
      S_IDLE: begin
        bit_we    = step;
        data_last = step && (DATA_BITS == 1);
      end
      S_DATA: begin
        bit_we    = step;
        data_last = step && (cnt_reg == LAST_DATA);
      end
      S_STOP:  stop_last = step && (cnt_reg == LAST_STOP);
      default: ;
    endcase
    case (mode_reg)
      3'd1:    expected_parity = acc_reg;
      3'd2:    expected_parity = ~acc_reg;
      3'd3:    expected_parity = 1'b1;
      default: expected_parity = 1'b0;
    endcase
  end

  // Data bits land at the index held in the counter. The counter is 0 in idle,
  // so the first strobe fills bit 0.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
    always_ff @(posedge clk) begin
      if (reset)                               shift_reg[gi] <= 1'b0;
      else if (bit_we && cnt_reg == CW'(gi))   shift_reg[gi] <= serial_in;
    end
  end

  // Frame datapath and reported results
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg    <= '0;
      mode_reg   <= '0;
      acc_reg    <= 1'b0;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        cnt_reg  <= '0;
        acc_reg  <= 1'b0;
        perr_reg <= 1'b0;
        ferr_reg <= 1'b0;
      end else if (sample_valid) begin
        case (state_reg)
          S_IDLE: begin
            mode_reg <= parity_mode;
            acc_reg  <= serial_in;
            cnt_reg  <= data_last ? '0 : CW'(1);
          end
          S_DATA: begin
            acc_reg <= acc_reg ^ serial_in;
            cnt_reg <= data_last ? '0 : cnt_reg + CW'(1);
          end
          S_PARITY: perr_reg <= (serial_in != expected_parity);
          S_STOP: begin
            if (stop_last) begin
              data_out   <= shift_reg;
              parity_err <= perr_reg;
              frame_err  <= ferr_reg | ~serial_in;
              frame_done <= 1'b1;
              cnt_reg    <= '0;
              acc_reg    <= 1'b0;
              perr_reg   <= 1'b0;
              ferr_reg   <= 1'b0;
            end else begin
              ferr_reg <= ferr_reg | ~serial_in;
              cnt_reg  <= cnt_reg + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The counters use the flags reported in the frame_done cycle.
  // clear_counts overrides a coincident increment.
  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      parity_err_count <= '0;
      frame_err_count  <= '0;
    end else if (frame_done) begin
      if (parity_err && parity_err_count != {CNT_W{1'b1}})
        parity_err_count <= parity_err_count + CNT_W'(1);
      if (frame_err && frame_err_count != {CNT_W{1'b1}})
        frame_err_count <= frame_err_count + CNT_W'(1);
    end
  end

endmodule
